// File: rtl/fetch_responder.sv
`default_nettype none
// ============================================================================
// Module      : fetch_responder
// Description : Answers matching fetch requests by streaming a burst of words
//               read from local storage through a ready/valid output.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_responder #(
   parameter int         DW     = 32,
   parameter logic [6:0] DEV_ID = 7'h05
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] i_ir,
   output logic          o_rd_en,
   output logic [7:0]    o_rd_addr,
   input  logic [DW-1:0] i_rd_data,
   output logic [DW-1:0] o_data,
   output logic          o_valid,
   input  logic          i_ready,
   output logic          o_busy,
   output logic          o_done,
   output logic          o_drop
);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_READ = 2'd1;
   localparam logic [1:0] c_WAIT = 2'd2;
   localparam logic [1:0] c_SEND = 2'd3;

   logic [1:0] r_state;
   logic [7:0] r_addr;
   logic [4:0] r_remaining;
   logic       w_match;
   logic       w_unused;

   assign w_match  = i_ir[0] && (i_ir[7:1] == DEV_ID);
   assign w_unused = ^i_ir[DW-1:20];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= c_IDLE;
         r_addr      <= 8'd0;
         r_remaining <= 5'd0;
         o_rd_en     <= 1'b0;
         o_rd_addr   <= 8'd0;
         o_data      <= '0;
         o_valid     <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_drop      <= 1'b0;
      end else begin
         o_rd_en <= 1'b0;
         o_done  <= 1'b0;
         o_drop  <= w_match && (r_state != c_IDLE);
         case (r_state)
            c_IDLE: begin
               if (w_match) begin
                  r_addr      <= i_ir[15:8];
                  // A zero count field encodes a full 16-word burst
                  r_remaining <= (i_ir[19:16] == 4'd0) ? 5'd16 : {1'b0, i_ir[19:16]};
                  o_rd_en     <= 1'b1;
                  o_rd_addr   <= i_ir[15:8];
                  o_busy      <= 1'b1;
                  r_state     <= c_READ;
               end
            end
            c_READ: begin
               r_state <= c_WAIT;
            end
            c_WAIT: begin
               o_data  <= i_rd_data;
               o_valid <= 1'b1;
               r_state <= c_SEND;
            end
            c_SEND: begin
               if (i_ready) begin
                  o_valid <= 1'b0;
                  if (r_remaining == 5'd1) begin
                     o_busy  <= 1'b0;
                     o_done  <= 1'b1;
                     r_state <= c_IDLE;
                  end else begin
                     r_addr      <= r_addr + 8'd1;
                     o_rd_addr   <= r_addr + 8'd1;
                     o_rd_en     <= 1'b1;
                     r_remaining <= r_remaining - 5'd1;
                     r_state     <= c_READ;
                  end
               end
            end
            default: begin
               o_busy  <= 1'b0;
               r_state <= c_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
